// File: rtl/fetch_unit.sv
// Program-counter / instruction-register fetch stage for a 16-entry instruction memory.
// Advances sequentially, honours jump and stall requests, and stops on a HALT opcode.
module fetch_unit #(
  parameter int unsigned word_size   = 8,
  parameter int unsigned index_size  = 4,
  parameter logic [3:0]  halt_opcode = 4'b1111
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [word_size-1:0]  ins_val,
  input  logic                  stall,
  input  logic                  jump_en,
  input  logic [index_size-1:0] jump_addr,
  output logic [index_size-1:0] prog_count,
  output logic [word_size-1:0]  ir_out,
  output logic                  ir_valid,
  output logic                  halted,
  output logic [7:0]            ins_count
);

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t                r_state, w_state_next;
  logic [index_size-1:0] r_pc, w_pc_next;
  logic [word_size-1:0]  r_ir, w_ir_next;
  logic                  r_valid, w_valid_next;
  logic                  r_halted, w_halted_next;
  logic [7:0]            r_count, w_count_next;

  logic                  w_is_halt;
  logic [7:0]            w_count_inc;
  logic [index_size-1:0] w_pc_inc;

  assign w_is_halt   = (ins_val[word_size-1 -: 4] == halt_opcode);
  assign w_count_inc = (r_count == 8'hFF) ? r_count : r_count + 8'd1;
  assign w_pc_inc    = r_pc + index_size'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_RUN;
      r_pc     <= '0;
      r_ir     <= '0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
      r_count  <= 8'd0;
    end else begin
      r_state  <= w_state_next;
      r_pc     <= w_pc_next;
      r_ir     <= w_ir_next;
      r_valid  <= w_valid_next;
      r_halted <= w_halted_next;
      r_count  <= w_count_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_pc_next     = r_pc;
    w_ir_next     = r_ir;
    w_valid_next  = r_valid;
    w_halted_next = r_halted;
    w_count_next  = r_count;
    case (r_state)
      S_RUN: begin
        // A jump beats a stall: the in-flight fetch is wrong-path and becomes a bubble.
        if (jump_en) begin
          w_pc_next    = jump_addr;
          w_valid_next = 1'b0;
        end else if (!stall) begin
          w_ir_next    = ins_val;
          w_valid_next = 1'b1;
          w_count_next = w_count_inc;
          if (w_is_halt) begin
            w_halted_next = 1'b1;
            w_state_next  = S_HALT;
          end else begin
            w_pc_next = w_pc_inc;
          end
        end
      end
      S_HALT: begin
        w_valid_next = 1'b0;
      end
      default: begin
        w_state_next = S_RUN;
      end
    endcase
  end

  assign prog_count = r_pc;
  assign ir_out     = r_ir;
  assign ir_valid   = r_valid;
  assign halted     = r_halted;
  assign ins_count  = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural model pushes the expected post-edge
// outputs for each cycle, and each scenario task pops and compares them after the edge.
module tb_fetch_unit;

  typedef struct packed {
    logic [3:0] pc;
    logic [7:0] ir;
    logic       v;
    logic       h;
    logic [7:0] cnt;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ins_val;
  logic       stall = 1'b0;
  logic       jump_en = 1'b0;
  logic [3:0] jump_addr = 4'd0;
  logic [3:0] prog_count;
  logic [7:0] ir_out;
  logic       ir_valid;
  logic       halted;
  logic [7:0] ins_count;

  logic [7:0] mem [16];
  assign ins_val = mem[prog_count];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model state
  logic [3:0] m_pc;
  logic [7:0] m_ir;
  logic       m_v;
  logic       m_h;
  logic [7:0] m_cnt;
  obs_t       sb[$];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk       (clk),
    .rst       (rst),
    .ins_val   (ins_val),
    .stall     (stall),
    .jump_en   (jump_en),
    .jump_addr (jump_addr),
    .prog_count(prog_count),
    .ir_out    (ir_out),
    .ir_valid  (ir_valid),
    .halted    (halted),
    .ins_count (ins_count)
  );

  function automatic obs_t obs();
    return {prog_count, ir_out, ir_valid, halted, ins_count};
  endfunction

  task automatic load_prog_a();
    logic [7:0] p [16];
    p = '{8'hD8, 8'h51, 8'hD5, 8'h52, 8'h40, 8'h41, 8'h42, 8'h43,
          8'h44, 8'hC0, 8'h46, 8'hF0, 8'h48, 8'h49, 8'h4A, 8'h4B};
    for (int i = 0; i < 16; i++) mem[i] = p[i];
  endtask

  task automatic load_prog_b();
    for (int i = 0; i < 16; i++) mem[i] = 8'h20 + 8'(i);
  endtask

  // Asserts reset away from a clock edge, checks the reset values, releases mid-cycle.
  task automatic do_reset(input string name);
    obs_t o;
    @(negedge clk);
    #2;
    rst = 1'b1;
    stall = 1'b0;
    jump_en = 1'b0;
    #1;
    o = obs();
    n_checks++;
    if (o !== obs_t'(0)) begin
      n_errors++;
      $display("FAIL %s reset_values: got %h expected %h", name, o, obs_t'(0));
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_pc = 4'd0; m_ir = 8'd0; m_v = 1'b0; m_h = 1'b0; m_cnt = 8'd0;
    sb.delete();
  endtask

  // One clock: drive inputs, push the model's expected outputs, sample #1 after the edge.
  task automatic step(input logic s, input logic j, input logic [3:0] ja);
    stall = s;
    jump_en = j;
    jump_addr = ja;
    if (m_h) begin
      m_v = 1'b0;
    end else if (j) begin
      m_pc = ja;
      m_v = 1'b0;
    end else if (!s) begin
      m_ir = mem[m_pc];
      m_v = 1'b1;
      if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      if (mem[m_pc][7:4] == 4'hF) m_h = 1'b1;
      else m_pc = m_pc + 4'd1;
    end
    sb.push_back({m_pc, m_ir, m_v, m_h, m_cnt});
    @(posedge clk);
    #1;
    cyc++;
    $display("cycle %0d: stall=%b jump=%b addr=%h -> pc=%h ir=%h v=%b h=%b cnt=%0d",
             cyc, s, j, ja, prog_count, ir_out, ir_valid, halted, ins_count);
    stall = 1'b0;
    jump_en = 1'b0;
  endtask

  task automatic test_reset();
    load_prog_a();
    do_reset("test_reset");
  endtask

  task automatic test_sequential();
    logic [7:0] seq [4];
    obs_t e;
    seq = '{8'hD8, 8'h51, 8'hD5, 8'h52};
    load_prog_a();
    do_reset("sequential");
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 4'd0);
      e = sb.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_errors++;
        $display("FAIL seq_sb[%0d]: got %h expected %h", i, obs(), e);
      end
      n_checks++;
      if ({ir_out, ir_valid, prog_count} !== {seq[i], 1'b1, 4'(i + 1)}) begin
        n_errors++;
        $display("FAIL seq_ir_pc[%0d]: got ir=%h v=%b pc=%h expected ir=%h v=1 pc=%h",
                 i, ir_out, ir_valid, prog_count, seq[i], 4'(i + 1));
      end
    end
    n_checks++;
    if (ins_count !== 8'd4) begin
      n_errors++;
      $display("FAIL seq_count: got %0d expected 4", ins_count);
    end
  endtask

  task automatic test_jump();
    obs_t e;
    load_prog_a();
    do_reset("jump");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 4'd0);
      e = sb.pop_front();
    end
    step(1'b0, 1'b1, 4'd9);
    e = sb.pop_front();
    n_checks++;
    if ({ir_valid, prog_count} !== {1'b0, 4'd9} || obs() !== e) begin
      n_errors++;
      $display("FAIL jump_bubble: got %h expected %h (v=0 pc=9)", obs(), e);
    end
    step(1'b0, 1'b0, 4'd0);
    e = sb.pop_front();
    n_checks++;
    if ({ir_out, ir_valid, prog_count} !== {8'hC0, 1'b1, 4'd10} || obs() !== e) begin
      n_errors++;
      $display("FAIL jump_target: got %h expected %h (ir=C0 v=1 pc=A)", obs(), e);
    end
  endtask

  task automatic test_stall();
    obs_t e;
    obs_t held;
    load_prog_a();
    do_reset("stall");
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 4'd0);
      e = sb.pop_front();
    end
    held = obs();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 4'd0);
      e = sb.pop_front();
      n_checks++;
      if (obs() !== e || obs() !== held || prog_count !== 4'd5) begin
        n_errors++;
        $display("FAIL stall_hold[%0d]: got %h expected %h", i, obs(), e);
      end
    end
    step(1'b1, 1'b1, 4'd0);
    e = sb.pop_front();
    n_checks++;
    if ({prog_count, ir_valid} !== {4'd0, 1'b0} || obs() !== e) begin
      n_errors++;
      $display("FAIL stall_jump: got %h expected %h (pc=0 v=0)", obs(), e);
    end
  endtask

  task automatic test_halt();
    obs_t e;
    load_prog_a();
    do_reset("halt");
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 4'd0);
      e = sb.pop_front();
    end
    n_checks++;
    if ({ir_out, ir_valid, halted, prog_count, ins_count} !== {8'hF0, 1'b1, 1'b1, 4'd11, 8'd12}
        || obs() !== e) begin
      n_errors++;
      $display("FAIL halt_capture: got %h expected %h (ir=F0 v=1 h=1 pc=B cnt=12)", obs(), e);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, (i == 1), 4'd2);
      e = sb.pop_front();
      n_checks++;
      if ({ir_valid, halted, prog_count, ins_count, ir_out} !== {1'b0, 1'b1, 4'd11, 8'd12, 8'hF0}
          || obs() !== e) begin
        n_errors++;
        $display("FAIL halt_hold[%0d]: got %h expected %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_wrap();
    obs_t e;
    load_prog_b();
    do_reset("wrap");
    for (int i = 0; i < 17; i++) begin
      step(1'b0, 1'b0, 4'd0);
      e = sb.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_errors++;
        $display("FAIL wrap_sb[%0d]: got %h expected %h", i, obs(), e);
      end
      if (i == 15) begin
        n_checks++;
        if (prog_count !== 4'd0) begin
          n_errors++;
          $display("FAIL wrap_pc: got %h expected 0", prog_count);
        end
      end
    end
    n_checks++;
    if ({ir_out, ins_count} !== {8'h20, 8'd17}) begin
      n_errors++;
      $display("FAIL wrap_17th: got ir=%h cnt=%0d expected ir=20 cnt=17", ir_out, ins_count);
    end
  endtask

  task automatic test_async_reset();
    obs_t e;
    load_prog_a();
    do_reset("async");
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0, 4'd0);
      e = sb.pop_front();
    end
    n_checks++;
    if (prog_count !== 4'd7) begin
      n_errors++;
      $display("FAIL async_pre_pc: got %h expected 7", prog_count);
    end
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if (obs() !== obs_t'(0)) begin
      n_errors++;
      $display("FAIL async_mid_reset: got %h expected %h", obs(), obs_t'(0));
    end
    @(negedge clk);
    rst = 1'b0;
    m_pc = 4'd0; m_ir = 8'd0; m_v = 1'b0; m_h = 1'b0; m_cnt = 8'd0;
    sb.delete();
    step(1'b0, 1'b0, 4'd0);
    e = sb.pop_front();
    n_checks++;
    if ({prog_count, ir_out, ir_valid} !== {4'd1, 8'hD8, 1'b1} || obs() !== e) begin
      n_errors++;
      $display("FAIL async_restart: got %h expected %h", obs(), e);
    end
  endtask

  task automatic test_saturation();
    obs_t e;
    load_prog_b();
    do_reset("saturation");
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b0, 4'd0);
      e = sb.pop_front();
      if (i == 254 || i == 255 || i == 299) begin
        n_checks++;
        if (obs() !== e || ins_count !== 8'd255) begin
          n_errors++;
          $display("FAIL sat_count[%0d]: got %h expected %h (cnt=255)", i, obs(), e);
        end
      end
    end
  endtask

  initial begin
    load_prog_a();
    m_pc = 4'd0; m_ir = 8'd0; m_v = 1'b0; m_h = 1'b0; m_cnt = 8'd0;
    test_reset();
    test_sequential();
    test_jump();
    test_stall();
    test_halt();
    test_wrap();
    test_async_reset();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
